// File: rtl/cmd_arbiter_if.sv
// Bundle of requester-side and cmd_logic-side signals around the SD CMD-line arbiter.
// The master modport is the environment (requesters + cmd_logic); slave is the arbiter.
interface cmd_arbiter_if #(
  parameter int NumReq = 3
);
  logic                   clk_en_p_i;
  logic                   abort_i;
  logic [NumReq-1:0]      req_valid_i;
  logic [NumReq*6-1:0]    req_cmd_i;
  logic [NumReq*32-1:0]   req_arg_i;
  logic [NumReq*2-1:0]    req_rsp_type_i;
  logic [NumReq-1:0]      req_ready_o;
  logic [NumReq-1:0]      done_o;
  logic                   done_err_o;
  logic [5:0]             cmd_o;
  logic [31:0]            arg_o;
  logic [1:0]             rsp_type_o;
  logic                   cmd_valid_o;
  logic                   cmd_ready_i;
  logic                   cmd_done_i;
  logic                   result_valid_i;
  logic                   rsp_err_i;
  logic                   timeout_i;
  logic [NumReq-1:0]      grant_o;
  logic                   busy_o;

  modport master (
    output clk_en_p_i, abort_i, req_valid_i, req_cmd_i, req_arg_i, req_rsp_type_i,
           cmd_ready_i, cmd_done_i, result_valid_i, rsp_err_i, timeout_i,
    input  req_ready_o, done_o, done_err_o, cmd_o, arg_o, rsp_type_o, cmd_valid_o,
           grant_o, busy_o
  );

  modport slave (
    input  clk_en_p_i, abort_i, req_valid_i, req_cmd_i, req_arg_i, req_rsp_type_i,
           cmd_ready_i, cmd_done_i, result_valid_i, rsp_err_i, timeout_i,
    output req_ready_o, done_o, done_err_o, cmd_o, arg_o, rsp_type_o, cmd_valid_o,
           grant_o, busy_o
  );
endinterface

// File: rtl/cmd_arbiter.sv
// Fixed-priority arbiter sharing one SD CMD-line engine between NumReq requesters,
// with an NCC idle gap (counted in sd_clk enables) between commands.
module cmd_arbiter #(
  parameter int NumReq    = 3,
  parameter int NccCycles = 8
) (
  input logic         clk_i,
  input logic         rst_ni,
  cmd_arbiter_if.slave bus
);

  localparam int              CntW    = $clog2(NccCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(NccCycles - 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(NccCycles);
  localparam logic [1:0]      RspNone = 2'b00;

  typedef enum logic [1:0] {Idle, Issue, Wait, Gap} state_e;

  state_e              state_q, state_d;
  logic [NumReq-1:0]   grant_q, grant_d;
  logic [NumReq-1:0]   req_ready_q, req_ready_d;
  logic [NumReq-1:0]   done_q, done_d;
  logic                done_err_q, done_err_d;
  logic [5:0]          cmd_q, cmd_d;
  logic [31:0]         arg_q, arg_d;
  logic [1:0]          rsp_type_q, rsp_type_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [NumReq-1:0]   pick;
  logic                end_evt;
  logic                end_err;

  // Isolate the lowest set bit: index 0 has the highest priority.
  function automatic logic [NumReq-1:0] lowest_onehot(input logic [NumReq-1:0] v);
    return v & (~v + NumReq'(1));
  endfunction

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    req_ready_d = '0;
    done_d      = '0;
    done_err_d  = 1'b0;
    cmd_d       = cmd_q;
    arg_d       = arg_q;
    rsp_type_d  = rsp_type_q;
    cmd_valid_d = cmd_valid_q;
    cnt_d       = cnt_q;
    pick        = lowest_onehot(bus.req_valid_i);
    end_evt     = 1'b0;
    end_err     = 1'b0;

    if (bus.abort_i) begin
      state_d     = Idle;
      grant_d     = '0;
      cmd_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        Idle: begin
          if (|bus.req_valid_i) begin
            for (int i = 0; i < NumReq; i++) begin
              if (pick[i]) begin
                cmd_d      = bus.req_cmd_i[i*6 +: 6];
                arg_d      = bus.req_arg_i[i*32 +: 32];
                rsp_type_d = bus.req_rsp_type_i[i*2 +: 2];
              end
            end
            grant_d     = pick;
            cmd_valid_d = 1'b1;
            state_d     = Issue;
          end
        end
        Issue: begin
          if (cmd_valid_q && bus.cmd_ready_i) begin
            req_ready_d = grant_q;
            cmd_valid_d = 1'b0;
            state_d     = Wait;
          end
        end
        Wait: begin
          // A timeout wins over a same-cycle result.
          if (rsp_type_q == RspNone) begin
            end_evt = bus.cmd_done_i;
          end else if (bus.timeout_i) begin
            end_evt = 1'b1;
            end_err = 1'b1;
          end else if (bus.result_valid_i) begin
            end_evt = 1'b1;
            end_err = bus.rsp_err_i;
          end
          if (end_evt) begin
            done_d     = grant_q;
            done_err_d = end_err;
            cnt_d      = '0;
            state_d    = Gap;
          end
        end
        Gap: begin
          if (bus.clk_en_p_i) begin
            if (cnt_q == CntLast) begin
              state_d = Idle;
              grant_d = '0;
            end else if (cnt_q != CntMax) begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = Idle;
      endcase
    end

    busy_d = (state_d != Idle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= Idle;
      grant_q     <= '0;
      req_ready_q <= '0;
      done_q      <= '0;
      done_err_q  <= 1'b0;
      cmd_q       <= '0;
      arg_q       <= '0;
      rsp_type_q  <= '0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      req_ready_q <= req_ready_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      rsp_type_q  <= rsp_type_d;
      cmd_valid_q <= cmd_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.grant_o     = grant_q;
  assign bus.req_ready_o = req_ready_q;
  assign bus.done_o      = done_q;
  assign bus.done_err_o  = done_err_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.arg_o       = arg_q;
  assign bus.rsp_type_o  = rsp_type_q;
  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.busy_o      = busy_q;

endmodule

// File: tb/tb_cmd_arbiter.sv
// Bench for cmd_arbiter: directed requester/cmd_logic scenarios, a transaction-level
// reference model compared every cycle, plus hand-computed literal expectations.
module tb_cmd_arbiter;
  localparam int N   = 3;
  localparam int Ncc = 8;
  localparam logic [1:0] R_NONE = 2'b00, R_R1 = 2'b01, R_R2 = 2'b10, R_R1B = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmd_arbiter_if #(.NumReq(N)) bus ();
  cmd_arbiter #(.NumReq(N), .NccCycles(Ncc)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  int ce_mode = 0;
  int ce_cyc = 0;
  logic [N-1:0] rdy_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_set(input logic [N-1:0] v);
    int r = 0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Reference model: who owns the engine, which phase of its command it is in,
  // and how many sd_clk enables of NCC are still owed.
  int           m_ph;
  int           m_left;
  logic [N-1:0] e_grant, e_rdy, e_done;
  logic         e_err, e_cv, e_busy;
  logic [5:0]   e_cmd;
  logic [31:0]  e_arg;
  logic [1:0]   e_rsp;
  assign e_busy = (m_ph != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph <= 0; m_left <= 0;
      e_grant <= '0; e_rdy <= '0; e_done <= '0; e_err <= 1'b0; e_cv <= 1'b0;
      e_cmd <= '0; e_arg <= '0; e_rsp <= '0;
    end else begin
      e_rdy <= '0; e_done <= '0; e_err <= 1'b0;
      if (bus.abort_i) begin
        m_ph <= 0; e_grant <= '0; e_cv <= 1'b0;
      end else begin
        case (m_ph)
          0: if (|bus.req_valid_i) begin
               e_grant <= N'(1) << first_set(bus.req_valid_i);
               e_cmd   <= bus.req_cmd_i[first_set(bus.req_valid_i)*6 +: 6];
               e_arg   <= bus.req_arg_i[first_set(bus.req_valid_i)*32 +: 32];
               e_rsp   <= bus.req_rsp_type_i[first_set(bus.req_valid_i)*2 +: 2];
               e_cv    <= 1'b1;
               m_ph    <= 1;
             end
          1: if (bus.cmd_ready_i) begin
               e_rdy <= e_grant; e_cv <= 1'b0; m_ph <= 2;
             end
          2: if ((e_rsp == R_NONE) ? bus.cmd_done_i : (bus.result_valid_i || bus.timeout_i)) begin
               e_done <= e_grant;
               e_err  <= (e_rsp != R_NONE) && (bus.timeout_i || bus.rsp_err_i);
               m_left <= Ncc;
               m_ph   <= 3;
             end
          default: if (bus.clk_en_p_i) begin
               m_left <= m_left - 1;
               if (m_left == 1) begin m_ph <= 0; e_grant <= '0; end
             end
        endcase
      end
    end
  end

  always @(negedge clk) begin
    chk("grant_o", bus.grant_o, e_grant);
    chk("req_ready_o", bus.req_ready_o, e_rdy);
    chk("done_o", bus.done_o, e_done);
    chk("done_err_o", bus.done_err_o, e_err);
    chk("cmd_valid_o", bus.cmd_valid_o, e_cv);
    chk("busy_o", bus.busy_o, e_busy);
    chk("cmd_o", bus.cmd_o, e_cmd);
    chk("arg_o", bus.arg_o, e_arg);
    chk("rsp_type_o", bus.rsp_type_o, e_rsp);
  end

  // Requesters drop valid after seeing ready; sd_clk enable pattern per ce_mode.
  initial begin
    bus.clk_en_p_i = 1'b1;
    forever begin
      @(negedge clk);
      rdy_seen = bus.req_ready_o;
      @(posedge clk);
      #1;
      bus.req_valid_i = bus.req_valid_i & ~rdy_seen;
      ce_cyc++;
      bus.clk_en_p_i = (ce_mode == 0) ? 1'b1 : ((ce_cyc % 4) == 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [5:0] c, input logic [31:0] a, input logic [1:0] r);
    bus.req_cmd_i[i*6 +: 6]      = c;
    bus.req_arg_i[i*32 +: 32]    = a;
    bus.req_rsp_type_i[i*2 +: 2] = r;
    bus.req_valid_i[i]           = 1'b1;
  endtask

  task automatic wait_cv(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.cmd_valid_o && n < 200) begin @(negedge clk); n++; end
    chk(name, bus.cmd_valid_o, 1);
  endtask

  task automatic handshake(input int dly, input string name);
    wait_cv(name);
    repeat (dly) @(negedge clk);
    bus.cmd_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.cmd_ready_i = 1'b0;
  endtask

  task automatic wait_rdy(input logic [N-1:0] exp, input string name);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready_o == '0 && n < 200) begin @(negedge clk); n++; end
    chk(name, bus.req_ready_o, exp);
  endtask

  task automatic pulse_ev(input logic rv, input logic er, input logic to, input logic cd);
    bus.result_valid_i = rv; bus.rsp_err_i = er; bus.timeout_i = to; bus.cmd_done_i = cd;
    @(posedge clk);
    #1;
    bus.result_valid_i = 1'b0; bus.rsp_err_i = 1'b0; bus.timeout_i = 1'b0; bus.cmd_done_i = 1'b0;
  endtask

  task automatic wait_done(input logic [N-1:0] exp, input logic exp_err, input string name);
    int n = 0;
    @(negedge clk);
    while (bus.done_o == '0 && n < 200) begin @(negedge clk); n++; end
    chk(name, bus.done_o, exp);
    chk({name, "_err"}, bus.done_err_o, exp_err);
  endtask

  task automatic no_done(input int cycles, input string name);
    int n = 0;
    repeat (cycles) begin @(negedge clk); if (bus.done_o != '0) n++; end
    chk(name, n, 0);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    @(negedge clk);
    while (bus.busy_o && n < 400) begin @(negedge clk); n++; end
    chk(name, bus.busy_o, 0);
  endtask

  initial begin
    int n;
    int c;
    bus.abort_i = 1'b0; bus.req_valid_i = '0; bus.req_cmd_i = '0; bus.req_arg_i = '0;
    bus.req_rsp_type_i = '0; bus.cmd_ready_i = 1'b0; bus.cmd_done_i = 1'b0;
    bus.result_valid_i = 1'b0; bus.rsp_err_i = 1'b0; bus.timeout_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant", bus.grant_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_cmd_valid", bus.cmd_valid_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Two pending requests, lower index wins, then the other after NCC.
    set_req(1, 6'd17, 32'h1000, R_R1);
    set_req(2, 6'd5, 32'hAAAA, R_R1);
    handshake(2, "t1_cv");
    wait_rdy(3'b010, "t1_rdy");
    chk("t1_cmd", bus.cmd_o, 17);
    chk("t1_arg", bus.arg_o, 32'h1000);
    chk("t1_grant", bus.grant_o, 3'b010);
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b010, 1'b0, "t1_done");
    handshake(0, "t1b_cv");
    wait_rdy(3'b100, "t1b_rdy");
    chk("t1b_cmd", bus.cmd_o, 5);
    pulse_ev(1'b1, 1'b1, 1'b0, 1'b0);
    wait_done(3'b100, 1'b1, "t1b_done");

    // Simultaneous req0/req2.
    wait_idle("t2_idle");
    set_req(0, 6'd2, 32'h11, R_R2);
    set_req(2, 6'd9, 32'h22, R_R1);
    handshake(0, "t2_cv");
    wait_rdy(3'b001, "t2_rdy");
    chk("t2_grant", bus.grant_o, 3'b001);
    chk("t2_cmd", bus.cmd_o, 2);
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b001, 1'b0, "t2_done");
    handshake(1, "t2b_cv");
    wait_rdy(3'b100, "t2b_rdy");
    chk("t2b_cmd", bus.cmd_o, 9);
    pulse_ev(1'b0, 1'b0, 1'b1, 1'b0);
    wait_done(3'b100, 1'b1, "t2b_done");

    // NO_RESPONSE command ends on cmd_done with no error even if rsp_err is high.
    wait_idle("t3_idle");
    set_req(0, 6'd0, 32'h0, R_NONE);
    handshake(1, "t3_cv");
    wait_rdy(3'b001, "t3_rdy");
    pulse_ev(1'b0, 1'b1, 1'b0, 1'b1);
    wait_done(3'b001, 1'b0, "t3_done");

    // R1b: cmd_done alone must not end it; timeout+result same cycle -> single error done.
    wait_idle("t4_idle");
    set_req(1, 6'd7, 32'h77, R_R1B);
    handshake(0, "t4_cv");
    wait_rdy(3'b010, "t4_rdy");
    pulse_ev(1'b0, 1'b0, 1'b0, 1'b1);
    pulse_ev(1'b1, 1'b0, 1'b1, 1'b0);
    wait_done(3'b010, 1'b1, "t4_done");
    no_done(12, "t4_single");

    // Abort in WAIT, late result ignored, then a normal grant.
    wait_idle("t5_idle");
    set_req(2, 6'd12, 32'h5, R_R1);
    handshake(0, "t5_cv");
    wait_rdy(3'b100, "t5_rdy");
    @(posedge clk);
    #1 bus.abort_i = 1'b1;
    @(posedge clk);
    #1 bus.abort_i = 1'b0;
    @(negedge clk);
    chk("t5_busy", bus.busy_o, 0);
    chk("t5_grant", bus.grant_o, 0);
    repeat (2) @(posedge clk);
    #1 pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    no_done(10, "t5_nodone");
    set_req(1, 6'd13, 32'h99, R_R1);
    handshake(0, "t5b_cv");
    wait_rdy(3'b010, "t5b_rdy");
    chk("t5b_cmd", bus.cmd_o, 13);
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b010, 1'b0, "t5b_done");

    // Abort beats a same-cycle cmd_ready; the still-valid requester is re-granted.
    wait_idle("t5c_idle");
    set_req(0, 6'd1, 32'h1, R_R1);
    wait_cv("t5c_cv");
    bus.abort_i = 1'b1; bus.cmd_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.abort_i = 1'b0; bus.cmd_ready_i = 1'b0;
    @(negedge clk);
    chk("t5c_rdy", bus.req_ready_o, 0);
    chk("t5c_busy", bus.busy_o, 0);
    handshake(0, "t5d_cv");
    wait_rdy(3'b001, "t5d_rdy");
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b001, 1'b0, "t5d_done");

    // NCC gap with sparse sd_clk enables; a newer higher-priority request wins.
    wait_idle("t6_idle");
    ce_mode = 1;
    set_req(0, 6'd17, 32'h1, R_R1);
    handshake(0, "t6_cv");
    wait_rdy(3'b001, "t6_rdy");
    set_req(2, 6'd20, 32'h2, R_R1);
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b001, 1'b0, "t6_done");
    set_req(1, 6'd21, 32'h3, R_R1);
    n = 0;
    c = 0;
    while (!bus.cmd_valid_o && c < 400) begin
      if (bus.clk_en_p_i) n++;
      @(negedge clk);
      c++;
    end
    chk("t6_pulses", n, 8);
    chk("t6_cycles_ge30", (c >= 30), 1);
    chk("t6_grant", bus.grant_o, 3'b010);
    chk("t6_cmd", bus.cmd_o, 21);
    handshake(0, "t6b_cv");
    wait_rdy(3'b010, "t6b_rdy");
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b010, 1'b0, "t6b_done");
    handshake(0, "t6c_cv");
    wait_rdy(3'b100, "t6c_rdy");
    chk("t6c_cmd", bus.cmd_o, 20);
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b100, 1'b0, "t6c_done");
    ce_mode = 0;

    // Asynchronous reset in WAIT.
    wait_idle("t7_idle");
    set_req(0, 6'd3, 32'h3, R_R1);
    handshake(0, "t7_cv");
    wait_rdy(3'b001, "t7_rdy");
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t7_busy", bus.busy_o, 0);
    chk("t7_grant", bus.grant_o, 0);
    chk("t7_cmd", bus.cmd_o, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    set_req(2, 6'd30, 32'hBEEF, R_R2);
    handshake(0, "t7b_cv");
    wait_rdy(3'b100, "t7b_rdy");
    chk("t7b_arg", bus.arg_o, 32'hBEEF);
    pulse_ev(1'b1, 1'b0, 1'b0, 1'b0);
    wait_done(3'b100, 1'b0, "t7b_done");
    wait_idle("t7_end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
